// File: rtl/vga_glyph_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : vga_glyph_pkg                                                    |
// | Purpose : Glyph geometry and serializer state encoding. Shared between the |
// |           pixel serializer and romController's parent.                     |
// | Contents: GLYPH_ROWS, GLYPH_COLS, glyph_state_e                            |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package vga_glyph_pkg;

  localparam int GLYPH_ROWS = 16;
  localparam int GLYPH_COLS = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    LOAD  = 3'd3,
    SHIFT = 3'd4,
    DONE  = 3'd5
  } glyph_state_e;

endpackage
`default_nettype wire

// File: rtl/glyph_pixel_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : glyph_pixel_serializer_if                                      |
// | Purpose   : valid/ready pixel stream from the glyph serializer to the VGA  |
// |             pixel mux.                                                     |
// | Signals   : pix_valid, pix_ready, pix_bit, pix_col[2:0], pix_row[3:0],     |
// |             pix_last                                                       |
// | Modports  : master (serializer side), slave (pixel mux side)               |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface glyph_pixel_serializer_if;

  logic       pix_valid;
  logic       pix_ready;
  logic       pix_bit;
  logic [2:0] pix_col;
  logic [3:0] pix_row;
  logic       pix_last;

  modport master (
    output pix_valid,
    output pix_bit,
    output pix_col,
    output pix_row,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_bit,
    input  pix_col,
    input  pix_row,
    input  pix_last,
    output pix_ready
  );

endinterface
`default_nettype wire

// File: rtl/glyph_row_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : glyph_row_shifter                                                |
// | Purpose : Holds one glyph row byte, tracks the current column and selects  |
// |           the pixel bit for that column.                                   |
// | Ports   : clock, reset      - clock, async active-high reset               |
// |           load, load_byte   - capture a new row, column back to 0          |
// |           advance           - pixel accepted downstream, step column       |
// |           col, pix_bit      - current column and its pixel value           |
// |           last_col          - column is COLS-1                             |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module glyph_row_shifter #(
  parameter int COLS      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic                     clock,
  input  wire logic                     reset,
  input  wire logic                     load,
  input  wire logic [COLS-1:0]          load_byte,
  input  wire logic                     advance,
  output logic      [$clog2(COLS)-1:0]  col,
  output logic                          pix_bit,
  output logic                          last_col
);

  localparam int                COL_W   = $clog2(COLS);
  localparam logic [COL_W-1:0]  COL_MAX = COL_W'(COLS - 1);

  logic [COLS-1:0]  row_bits_q, row_bits_d;
  logic [COL_W-1:0] col_q, col_d;

  always_comb begin
    row_bits_d = row_bits_q;
    col_d      = col_q;
    if (load) begin
      row_bits_d = load_byte;
      col_d      = '0;
    end else if (advance) begin
      // The column only leaves COL_MAX through a row change, so the
      // return to 0 here is explicit rather than relying on overflow.
      col_d = (col_q == COL_MAX) ? '0 : col_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      row_bits_q <= '0;
      col_q      <= '0;
    end else begin
      row_bits_q <= row_bits_d;
      col_q      <= col_d;
    end
  end

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign pix_bit = row_bits_q[COL_MAX - col_q];
    end else begin : g_lsb_first
      assign pix_bit = row_bits_q[col_q];
    end
  endgenerate

  assign col      = col_q;
  assign last_col = (col_q == COL_MAX);

endmodule
`default_nettype wire

// File: rtl/glyph_pixel_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : glyph_pixel_serializer                                           |
// | Purpose : Fetches the rows of one glyph from romController and streams     |
// |           them out as valid/ready pixels, row by row.                      |
// | Ports   : clock, reset          - clock, async active-high reset           |
// |           start, digit          - render request and glyph code            |
// |           busy, done            - in-progress flag, completion pulse       |
// |           rom_enable, rom_num,  - romController fetch request              |
// |           rom_offset                                                       |
// |           rom_byte              - row byte returned by romController       |
// |           pix                   - pixel stream (master side)               |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
import vga_glyph_pkg::*;

module glyph_pixel_serializer #(
  parameter int ROWS      = GLYPH_ROWS,
  parameter int COLS      = GLYPH_COLS,
  parameter bit MSB_FIRST = 1'b1
) (
  input  wire logic            clock,
  input  wire logic            reset,
  input  wire logic            start,
  input  wire logic [2:0]      digit,
  output logic                 busy,
  output logic                 done,
  output logic                 rom_enable,
  output logic      [2:0]      rom_num,
  output logic      [3:0]      rom_offset,
  input  wire logic [COLS-1:0] rom_byte,
  glyph_pixel_serializer_if.master pix
);

  localparam logic [3:0] ROW_MAX = 4'(ROWS - 1);

  glyph_state_e state_q, state_d;
  logic [2:0]   digit_q, digit_d;
  logic [3:0]   row_q, row_d;

  logic         shift_hs;
  logic         last_col;
  logic         shifter_bit;
  logic [2:0]   shifter_col;
  logic         blank_glyph;
  logic [COLS-1:0] load_byte;

  // Codes with bit 2 set have no ROM entry: they render as blank and the
  // ROM is never asked for them.
  assign blank_glyph = digit_q[2];
  assign shift_hs    = (state_q == SHIFT) && pix.pix_ready;
  assign load_byte   = blank_glyph ? '0 : rom_byte;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   state_d = WAIT;
      WAIT:    state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT: begin
        if (shift_hs && last_col) begin
          state_d = (row_q == ROW_MAX) ? DONE : FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latched glyph code and row counter. The row only moves on the final
  // pixel handshake of a row, so rom_num/rom_offset are stable through
  // every FETCH/WAIT pair.
  always_comb begin
    digit_d = digit_q;
    row_d   = row_q;
    if ((state_q == IDLE) && start) begin
      digit_d = digit;
      row_d   = '0;
    end else if (shift_hs && last_col && (row_q != ROW_MAX)) begin
      row_d = row_q + 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      digit_q <= '0;
      row_q   <= '0;
    end else begin
      digit_q <= digit_d;
      row_q   <= row_d;
    end
  end

  glyph_row_shifter #(
    .COLS      (COLS),
    .MSB_FIRST (MSB_FIRST)
  ) u_row_shifter (
    .clock     (clock),
    .reset     (reset),
    .load      (state_q == LOAD),
    .load_byte (load_byte),
    .advance   (shift_hs),
    .col       (shifter_col),
    .pix_bit   (shifter_bit),
    .last_col  (last_col)
  );

  // Outputs are decoded from registered state only, so an asynchronous
  // reset clears them in the same cycle.
  always_comb begin
    busy          = (state_q != IDLE);
    done          = (state_q == DONE);
    rom_enable    = (state_q == FETCH) && !blank_glyph;
    rom_num       = digit_q;
    rom_offset    = row_q;
    pix.pix_valid = (state_q == SHIFT);
    pix.pix_bit   = shifter_bit;
    pix.pix_col   = shifter_col;
    pix.pix_row   = row_q;
    pix.pix_last  = (state_q == SHIFT) && (row_q == ROW_MAX) && last_col;
  end

endmodule
`default_nettype wire

// File: tb/tb_glyph_pixel_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_glyph_pixel_serializer                                        |
// | Purpose : Directed bench for glyph_pixel_serializer with a small ROM       |
// |           responder returning row r = 8'hA5 ^ r.                           |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_glyph_pixel_serializer;

  logic       clock;
  logic       reset;
  logic       start;
  logic [2:0] digit;
  logic       busy;
  logic       done;
  logic       rom_enable;
  logic [2:0] rom_num;
  logic [3:0] rom_offset;
  logic [7:0] rom_byte;

  int checks = 0;
  int errors = 0;

  glyph_pixel_serializer_if pif ();

  glyph_pixel_serializer dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .digit      (digit),
    .busy       (busy),
    .done       (done),
    .rom_enable (rom_enable),
    .rom_num    (rom_num),
    .rom_offset (rom_offset),
    .rom_byte   (rom_byte),
    .pix        (pif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // romController stand-in: latches the addressed row on a clock edge
  // where its enable is high.
  always @(posedge clock or posedge reset) begin
    if (reset) rom_byte <= 8'h00;
    else if (rom_enable) rom_byte <= 8'hA5 ^ {4'h0, rom_offset};
  end

  task automatic check_value(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return {18'd0, busy, done, rom_enable, rom_num, rom_offset,
            pif.pix_valid, pif.pix_bit, pif.pix_col, pif.pix_row, pif.pix_last};
  endfunction

  // Renders one glyph. rnd_ready stalls the stream randomly; inject pulses
  // start mid-glyph and on the done cycle.
  task automatic run_glyph(input logic [2:0] dig, input bit rnd_ready, input bit inject);
    int         t, k, first_t, last_hs_t, en_cnt, done_cnt;
    bit         new_row;
    logic [7:0] rb, row0;
    logic [8:0] exp_px;
    @(negedge clock);
    start = 1'b1;
    digit = dig;
    @(negedge clock);
    start = 1'b0;
    digit = dig ^ 3'b011;
    t = 1; k = 0; first_t = -1; last_hs_t = 0; en_cnt = 0; done_cnt = 0;
    new_row = 1'b0; row0 = 8'h00;
    while (k < 128 && t < 2000) begin
      pif.pix_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (inject && t == 50) begin
        start = 1'b1;
        digit = 3'b110;
      end else begin
        start = 1'b0;
      end
      if (rom_enable) begin
        en_cnt++;
        check_value("rom_num", 32'(rom_num), 32'(dig));
        check_value("rom_offset", 32'(rom_offset), k / 8);
      end
      if (done) done_cnt++;
      if (pif.pix_valid) begin
        if (first_t < 0) first_t = t;
        if (new_row) begin
          if (!rnd_ready) check_value("row_bubble", t - last_hs_t, 4);
          new_row = 1'b0;
        end
        rb     = dig[2] ? 8'h00 : (8'hA5 ^ 8'(k / 8));
        exp_px = {rb[7 - (k % 8)], 3'(k % 8), 4'(k / 8), (k == 127)};
        check_value("pixel", {pif.pix_bit, pif.pix_col, pif.pix_row, pif.pix_last}, exp_px);
        if (pif.pix_ready) begin
          if (k < 8) row0[7 - k] = pif.pix_bit;
          if (k % 8 == 7) begin
            new_row   = 1'b1;
            last_hs_t = t;
          end
          k++;
        end
      end
      @(negedge clock);
      t++;
    end
    start = 1'b0;
    check_value("pixel_count", k, 128);
    check_value("first_valid", first_t, 4);
    check_value("rom_pulses", en_cnt, dig[2] ? 0 : 16);
    check_value("early_done", done_cnt, 0);
    check_value("row0_bits", row0, dig[2] ? 8'h00 : 8'b1010_0101);
    check_value("done_pulse", {busy, done, pif.pix_valid}, 3'b110);
    if (inject) begin
      start = 1'b1;
      digit = 3'b001;
    end
    @(negedge clock);
    start = 1'b0;
    check_value("after_done", {busy, done, pif.pix_valid, rom_enable}, 4'b0000);
    @(negedge clock);
    check_value("idle_hold", {busy, rom_enable}, 2'b00);
  endtask

  initial begin
    bit found;
    reset = 1'b1;
    start = 1'b0;
    digit = 3'd0;
    pif.pix_ready = 1'b0;
    repeat (2) @(negedge clock);
    check_value("reset_state", all_outputs(), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check_value("idle_state", all_outputs(), 32'd0);

    // Normal glyph, always ready, with row timing
    run_glyph(3'd3, 1'b0, 1'b0);
    // Blank glyph: ROM untouched, all pixels 0
    run_glyph(3'd5, 1'b0, 1'b0);
    // Random back-pressure plus ignored start pulses
    run_glyph(3'd3, 1'b1, 1'b1);

    // Abort mid-glyph at row 7 col 3
    @(negedge clock);
    start = 1'b1;
    digit = 3'd2;
    pif.pix_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (pif.pix_valid && pif.pix_row == 4'd7 && pif.pix_col == 3'd3) begin
        found = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check_value("reach_r7c3", 32'(found), 32'd1);
    reset = 1'b1;
    #1;
    check_value("abort_clear", all_outputs(), 32'd0);
    @(negedge clock);
    check_value("abort_hold", all_outputs(), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check_value("abort_no_done", {busy, done}, 2'b00);
    run_glyph(3'd3, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
